// File: rtl/alarm_bank_module_if.sv
// ---------------------------------------------------------------------------
// alarm_bank_module_if
//
// Groups the set-time/alarm bus between the set-time stage (master) and the
// alarm bank (slave).
//   TICK        1 Hz one-cycle time base pulse
//   STI         13-bit alarm word {enable, hh[4:0], m_tens[2:0], m_units[3:0]}
//   ST_DAY      target day for a load (7 = no-op)
//   LD_ALARM    load strobe for STI into register ST_DAY
//   CTI         15-bit current time {day[2:0], time[11:0]}
//   SNOOZE/STOP level buttons
//   Q_r0..Q_r6  stored per-day alarm words (read back by the set-time stage)
//   ALARM       buzzer drive
//   SNOOZING    high while snoozing
//   RING_STATE  0 IDLE, 1 RINGING, 2 SNOOZE, 3 DONE
// ---------------------------------------------------------------------------
interface alarm_bank_module_if;
   logic        TICK;
   logic [12:0] STI;
   logic [2:0]  ST_DAY;
   logic        LD_ALARM;
   logic [14:0] CTI;
   logic        SNOOZE;
   logic        STOP;
   logic [12:0] Q_r0;
   logic [12:0] Q_r1;
   logic [12:0] Q_r2;
   logic [12:0] Q_r3;
   logic [12:0] Q_r4;
   logic [12:0] Q_r5;
   logic [12:0] Q_r6;
   logic        ALARM;
   logic        SNOOZING;
   logic [1:0]  RING_STATE;

   modport master (
      output TICK, STI, ST_DAY, LD_ALARM, CTI, SNOOZE, STOP,
      input  Q_r0, Q_r1, Q_r2, Q_r3, Q_r4, Q_r5, Q_r6,
      input  ALARM, SNOOZING, RING_STATE
   );

   modport slave (
      input  TICK, STI, ST_DAY, LD_ALARM, CTI, SNOOZE, STOP,
      output Q_r0, Q_r1, Q_r2, Q_r3, Q_r4, Q_r5, Q_r6,
      output ALARM, SNOOZING, RING_STATE
   );
endinterface

// File: rtl/alarm_bank_module.sv
// ---------------------------------------------------------------------------
// alarm_bank_module
//
// Holds seven per-weekday alarm words, compares the current day's word with
// the running clock and runs the ring/snooze state machine for the buzzer.
//   CLK    system clock (rising edge)
//   CLEAR  synchronous active-high reset
//   bus    alarm_bank_module_if.slave: load port, current time, buttons,
//          stored words, buzzer and state outputs
// ---------------------------------------------------------------------------
module alarm_bank_module #(
   parameter int RING_TICKS   = 60,
   parameter int SNOOZE_TICKS = 300,
   parameter int MAX_SNOOZE   = 3
) (
   input  logic                 CLK,
   input  logic                 CLEAR,
   alarm_bank_module_if.slave   bus
);

   localparam int MAX_TICKS = (RING_TICKS > SNOOZE_TICKS) ? RING_TICKS : SNOOZE_TICKS;
   localparam int CNT_W     = $clog2(MAX_TICKS + 1);
   localparam int SN_W      = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);

   localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_TICKS - 1);
   localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_TICKS - 1);
   localparam logic [SN_W-1:0]  SNOOZE_MAX  = SN_W'(MAX_SNOOZE);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZE  = 2'd2,
      DONE    = 2'd3
   } state_t;

   logic [12:0]      q_r [7];
   logic [12:0]      sel_word;
   logic [2:0]       cti_day;
   logic             match;
   logic             match_q;
   logic             trigger;
   logic             snooze_q;
   logic             stop_q;
   logic             snooze_edge;
   logic             stop_edge;
   logic             cancel;
   state_t           state, state_nxt;
   logic [CNT_W-1:0] tick_cnt, tick_nxt;
   logic [SN_W-1:0]  snooze_cnt, snooze_nxt;

   // Register file: only LD_ALARM with a valid day writes.
   always_ff @(posedge CLK) begin
      if (CLEAR) begin
         for (int i = 0; i < 7; i++) q_r[i] <= '0;
      end else if (bus.LD_ALARM && (bus.ST_DAY != 3'd7)) begin
         q_r[bus.ST_DAY] <= bus.STI;
      end
   end

   assign bus.Q_r0 = q_r[0];
   assign bus.Q_r1 = q_r[1];
   assign bus.Q_r2 = q_r[2];
   assign bus.Q_r3 = q_r[3];
   assign bus.Q_r4 = q_r[4];
   assign bus.Q_r5 = q_r[5];
   assign bus.Q_r6 = q_r[6];

   // Match uses the registered words, so a load in the same cycle still sees
   // the old value. Day 7 selects nothing and never matches.
   assign cti_day = bus.CTI[14:12];

   always_comb begin
      sel_word = '0;
      if (cti_day != 3'd7) sel_word = q_r[cti_day];
   end

   assign match       = sel_word[12] && (sel_word[11:0] == bus.CTI[11:0]);
   assign trigger     = match && !match_q;
   assign snooze_edge = bus.SNOOZE && !snooze_q;
   assign stop_edge   = bus.STOP && !stop_q;

   // Disabling the word that is currently being compared aborts an active alarm.
   assign cancel = bus.LD_ALARM && (bus.ST_DAY != 3'd7) && (bus.ST_DAY == cti_day)
                   && !bus.STI[12];

   always_ff @(posedge CLK) begin
      if (CLEAR) begin
         match_q    <= 1'b0;
         snooze_q   <= 1'b0;
         stop_q     <= 1'b0;
         state      <= IDLE;
         tick_cnt   <= '0;
         snooze_cnt <= '0;
      end else begin
         match_q    <= match;
         snooze_q   <= bus.SNOOZE;
         stop_q     <= bus.STOP;
         state      <= state_nxt;
         tick_cnt   <= tick_nxt;
         snooze_cnt <= snooze_nxt;
      end
   end

   // Next-state logic; priority cancel > STOP > SNOOZE > TICK timeout.
   // Counters stop at their terminal values, so they can never wrap.
   always_comb begin
      state_nxt  = state;
      tick_nxt   = tick_cnt;
      snooze_nxt = snooze_cnt;
      unique case (state)
         IDLE: begin
            if (trigger) begin
               state_nxt  = RINGING;
               tick_nxt   = '0;
               snooze_nxt = '0;
            end
         end
         RINGING: begin
            if (cancel || stop_edge) begin
               state_nxt = DONE;
            end else if (snooze_edge) begin
               if (snooze_cnt < SNOOZE_MAX) begin
                  state_nxt  = SNOOZE;
                  snooze_nxt = snooze_cnt + SN_W'(1);
                  tick_nxt   = '0;
               end else begin
                  state_nxt = DONE;
               end
            end else if (bus.TICK) begin
               if (tick_cnt == RING_LAST) state_nxt = DONE;
               else                       tick_nxt  = tick_cnt + CNT_W'(1);
            end
         end
         SNOOZE: begin
            if (cancel || stop_edge) begin
               state_nxt = DONE;
            end else if (bus.TICK) begin
               if (tick_cnt == SNOOZE_LAST) begin
                  state_nxt = RINGING;
                  tick_nxt  = '0;
               end else begin
                  tick_nxt = tick_cnt + CNT_W'(1);
               end
            end
         end
         DONE: begin
            if (!match) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.ALARM      = (state == RINGING);
   assign bus.SNOOZING   = (state == SNOOZE);
   assign bus.RING_STATE = state;

endmodule
